// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file: operation
// encodings and the architectural upper bound on register count.
package regfile_pkg;

  localparam int DEPTH_MAX = 16;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

endpackage

// File: rtl/regfile_op_unit.sv
// Combinational in-place operation for one register: produces the new value,
// the new carry/zero flags, and whether the operation touches the flags.
module regfile_op_unit
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_out,
  output logic             flags_en
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result    = value;
    carry_out = carry_in;
    case (op)
      OP_HOLD: result = value;
      OP_LOAD: result = bus_in;
      OP_INC: begin
        result    = value + WIDTH'(1);
        carry_out = &value;
      end
      OP_DEC: begin
        result    = value - WIDTH'(1);
        carry_out = ~|value;
      end
      OP_SHL: begin
        result    = {value[WIDTH-2:0], 1'b0};
        carry_out = value[WIDTH-1];
      end
      OP_SHR: begin
        result    = {1'b0, value[WIDTH-1:1]};
        carry_out = value[0];
      end
      OP_ROL: begin
        result    = {value[WIDTH-2:0], carry_in};
        carry_out = value[WIDTH-1];
      end
      OP_CLR: begin
        result    = '0;
        carry_out = 1'b0;
      end
    endcase
  end

  // HOLD and LOAD leave both flags alone; everything else refreshes them.
  assign flags_en = (op != OP_HOLD) && (op != OP_LOAD);
  assign zero_out = (result == '0);

endmodule

// File: rtl/gp_regfile.sv
// DEPTH x WIDTH register file on the CPU bus with in-place operations,
// carry/zero flags, a split tristate bus interface and fixed ALU taps.
module gp_regfile
  import regfile_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  input  logic             we_n,
  input  logic             oe_n,
  input  logic [SEL_W-1:0] wsel,
  input  logic [SEL_W-1:0] rsel,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             carry,
  output logic             zero
);

  localparam logic [SEL_W:0] DEPTH_L = (SEL_W + 1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wsel_ok;
  logic             rsel_ok;
  logic             write_en;
  logic [WIDTH-1:0] old_value;
  logic [WIDTH-1:0] result;
  logic             carry_next;
  logic             zero_next;
  logic             flags_en;

  // Non-power-of-two depths leave select codes with no register behind them.
  assign wsel_ok   = ({1'b0, wsel} < DEPTH_L);
  assign rsel_ok   = ({1'b0, rsel} < DEPTH_L);
  assign write_en  = ~we_n && wsel_ok;
  assign old_value = wsel_ok ? regs[wsel] : '0;

  regfile_op_unit #(
    .WIDTH(WIDTH)
  ) u_op_unit (
    .op       (op_e'(op)),
    .value    (old_value),
    .bus_in   (bus_in),
    .carry_in (carry),
    .result   (result),
    .carry_out(carry_next),
    .zero_out (zero_next),
    .flags_en (flags_en)
  );

  // NOTE: the storage is built from flops, not a RAM macro, so clr can clear every entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (write_en) begin
      // NOTE: non-blocking updates keep the read mux seeing pre-edge state.
      regs[wsel] <= result;
      if (flags_en) begin
        carry <= carry_next;
        zero  <= zero_next;
      end
    end
  end

  assign bus_oe  = ~oe_n;
  assign bus_out = (~oe_n && rsel_ok) ? regs[rsel] : '0;
  assign alu_a   = regs[0];
  assign alu_b   = regs[1];

endmodule
